segre_store_buffer: RTL and testbench
=====================================

# segre_store_buffer

In-order FIFO store buffer between the TL/MEM pipeline boundary and the MEM-stage data cache. Committed stores are queued here instead of writing the cache immediately. The queue drains head-first into the data cache whenever the cache write port is free. Loads are looked up combinationally so the MEM stage can forward buffered data (`hit_o`/`ld_data_o`) and stall on partial overlaps.

## Interface
- `NUM_ENTRIES`, default 4; buffer depth, power of two, ≥2.
- `WORD_SIZE`, default 32; data width.
- `ADDR_SIZE`, default 32; address width.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rsn_i`  in  1  reset; synchronous, active-high (1 = reset).
- `st_valid_i`  in  1  push request: store to enqueue.
- `st_addr_i`  in  ADDR_SIZE  store byte address.
- `st_data_i`  in  WORD_SIZE  store data, right-aligned.
- `st_type_i`  in  memop_data_type_e  BYTE/HALF/WORD.
- `ld_valid_i`  in  1  a load is being looked up this cycle.
- `ld_addr_i`  in  ADDR_SIZE  load byte address.
- `ld_type_i`  in  memop_data_type_e  load size.
- `hit_o`  out  1  comb: exact-match forward available.
- `ld_data_o`  out  WORD_SIZE  comb: forwarded data, right-aligned, not extended.
- `conflict_o`  out  1  comb: partial overlap; MEM must stall the load.
- `drain_valid_o`  out  1  head entry valid for cache write.
- `drain_addr_o`  out  ADDR_SIZE  head address.
- `drain_data_o`  out  WORD_SIZE  head data.
- `drain_type_o`  out  memop_data_type_e  head size.
- `drain_ready_i`  in  1  cache write port free this cycle.
- `full_o`  out  1  count == NUM_ENTRIES.
- `empty_o`  out  1  count == 0.

## Operation
**Storage**
- Circular array of NUM_ENTRIES entries {valid, addr, data, type}.
- Head pointer, tail pointer, count; count is $clog2(NUM_ENTRIES)+1 bits wide.
- Both pointers wrap modulo NUM_ENTRIES.

**Push**
- Accepted when `st_valid_i` && !`full_o`.
- Entry is written at tail; tail++ and valid set.
- `st_valid_i` while full is dropped. The producer stalls on `full_o`, and verification asserts this never occurs.

**Pop**
- Occurs when `drain_valid_o` && `drain_ready_i`.
- Head valid is cleared and head++.
- `drain_*` are driven from the head entry.
- `drain_valid_o` = !`empty_o`.

**Simultaneous push and pop**
- Both act in the same cycle and count is unchanged.
- When full, pop proceeds and the push is rejected (`full_o` is registered).
- When count == 1, the pushed entry becomes the new head next cycle.

**Lookup** (combinational; only valid entries are searched, never the same-cycle push)
- Word match: entry.addr[ADDR_SIZE-1:2] == ld_addr_i[ADDR_SIZE-1:2].
- Exact match: entry.addr == ld_addr_i && entry.type == ld_type_i.
- The youngest matching entry (closest to tail) wins.
- If the youngest word-matching entry is an exact match: `hit_o`=1 and `ld_data_o`=entry.data.
- If it is word-matching but not exact: `conflict_o`=1 and `hit_o`=0.
- With no word match: both outputs are 0.
- When `ld_valid_i`=0, `hit_o`, `conflict_o` and `ld_data_o` are all 0.
- `hit_o` and `conflict_o` are mutually exclusive.

**Reset**
- Clears all valid bits, pointers and count.
- Buffered stores are discarded, including during reset mid-drain.
- No flush of pending entries to the cache occurs.

## Timing
- Push at edge N: entry visible to lookup and `empty_o`/`full_o` from cycle N+1.
- If the buffer was empty, `drain_valid_o`=1 from N+1. Minimum store-to-cache latency is 1 cycle.
- Pop at edge N: next head presented in cycle N+1. Sustained drain rate is 1 store/cycle.
- `drain_*` are stable while `drain_valid_o`=1 and `drain_ready_i`=0.
- Lookup outputs have zero latency, combinational from `ld_*` and the registered state.
- Reset values:
  - `drain_valid_o`=0, `full_o`=0, `empty_o`=1.
  - `drain_addr_o`/`drain_data_o`=0, `drain_type_o`=BYTE.
  - `hit_o`=0, `conflict_o`=0, `ld_data_o`=0.
- Reset applies one cycle after `rsn_i`=1 is sampled. Outputs hold reset values while `rsn_i`=1.

## Test plan
1. **Push then drain.** Push WORD 0x1000/0xDEADBEEF with `drain_ready_i`=0.
   - Next cycle: `drain_valid_o`=1, addr 0x1000, data 0xDEADBEEF, `empty_o`=0.
   - Raise `drain_ready_i`: `empty_o`=1 the following cycle.
2. **Fill and wrap.** Push 4 stores while `drain_ready_i`=0.
   - `full_o`=1, and a 5th push is dropped.
   - Drain 2, push 2, then drain all: the order out equals the order in across the pointer wrap.
3. **Youngest-wins forwarding.** Push WORD 0x2000/0x11111111, then WORD 0x2000/0x22222222. Look up WORD 0x2000.
   - Required: `hit_o`=1, `ld_data_o`=0x22222222.
4. **Partial overlap.** Buffer holds BYTE 0x3001/0xAB. Look up WORD 0x3000.
   - Required: `conflict_o`=1, `hit_o`=0.
   - After the entry drains, the same lookup gives both 0.
5. **Simultaneous push and pop at count 1.**
   - Push 0x4000 and pop 0x3FFC in the same cycle: count stays 1, head next cycle is 0x4000.
   - Same-cycle lookup of 0x4000 gives `hit_o`=0.
6. **Reset mid-operation.** Assert `rsn_i`=1 with 3 entries buffered.
   - Next cycle: `empty_o`=1, `drain_valid_o`=0, and lookups of those addresses give `hit_o`=0.

Source files
------------

// File: rtl/segre_store_buffer.sv
// segre_store_buffer
//   In-order FIFO of committed stores sitting between the TL/MEM boundary and
//   the MEM-stage data cache. Stores drain head-first whenever the cache write
//   port is free. Loads search the buffer combinationally:
//     - an exact hit forwards the buffered data;
//     - a partial overlap raises a conflict so that MEM stalls the load.
//
// Ports
//   clk_i, rsn_i                clock, synchronous active-high reset
//   st_valid_i/addr/data/type   store push request
//   ld_valid_i/addr/type        load lookup request
//   hit_o, ld_data_o            exact-match forward (combinational)
//   conflict_o                  partial overlap, stall the load (combinational)
//   drain_valid_o/addr/data/type, drain_ready_i   head entry towards the cache
//   full_o, empty_o             occupancy flags

package segre_sb_pkg;
  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } memop_data_type_e;
endpackage

module segre_store_buffer
  import segre_sb_pkg::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int WORD_SIZE   = 32,
  parameter int ADDR_SIZE   = 32
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 st_valid_i,
  input  logic [ADDR_SIZE-1:0] st_addr_i,
  input  logic [WORD_SIZE-1:0] st_data_i,
  input  memop_data_type_e     st_type_i,
  input  logic                 ld_valid_i,
  input  logic [ADDR_SIZE-1:0] ld_addr_i,
  input  memop_data_type_e     ld_type_i,
  output logic                 hit_o,
  output logic [WORD_SIZE-1:0] ld_data_o,
  output logic                 conflict_o,
  output logic                 drain_valid_o,
  output logic [ADDR_SIZE-1:0] drain_addr_o,
  output logic [WORD_SIZE-1:0] drain_data_o,
  output memop_data_type_e     drain_type_o,
  input  logic                 drain_ready_i,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int PTR_W = $clog2(NUM_ENTRIES);
  localparam int CNT_W = PTR_W + 1;

  logic [NUM_ENTRIES-1:0] valid_q;
  logic [ADDR_SIZE-1:0]   addr_q [NUM_ENTRIES];
  logic [WORD_SIZE-1:0]   data_q [NUM_ENTRIES];
  memop_data_type_e       type_q [NUM_ENTRIES];
  logic [PTR_W-1:0]       head_q, tail_q;
  logic [CNT_W-1:0]       count_q;

  logic push, pop;

  assign full_o        = (count_q == CNT_W'(NUM_ENTRIES));
  assign empty_o       = (count_q == '0);
  assign drain_valid_o = !empty_o;

  // A push is refused while full even if the head pops in the same cycle,
  // since full_o comes from the registered count.
  assign push = st_valid_i && !full_o;
  assign pop  = drain_valid_o && drain_ready_i;

  // Drain outputs read as zero/BYTE while empty so stale payload never leaks
  // out after reset or after the last pop.
  assign drain_addr_o = drain_valid_o ? addr_q[head_q] : '0;
  assign drain_data_o = drain_valid_o ? data_q[head_q] : '0;
  assign drain_type_o = drain_valid_o ? type_q[head_q] : BYTE;

  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload needs no reset: it is only observed through valid entries.
  always_ff @(posedge clk_i) begin
    if (push && !rsn_i) begin
      addr_q[tail_q] <= st_addr_i;
      data_q[tail_q] <= st_data_i;
      type_q[tail_q] <= st_type_i;
    end
  end

  // Walk from oldest to youngest; the last word match seen is the youngest,
  // so it overrides any older one.
  always_comb begin
    logic [PTR_W-1:0]     idx;
    logic                 found;
    logic                 exact;
    logic [WORD_SIZE-1:0] fwd_data;
    idx        = '0;
    found      = 1'b0;
    exact      = 1'b0;
    fwd_data   = '0;
    hit_o      = 1'b0;
    conflict_o = 1'b0;
    ld_data_o  = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      idx = head_q + PTR_W'(i);
      if (valid_q[idx] && (addr_q[idx][ADDR_SIZE-1:2] == ld_addr_i[ADDR_SIZE-1:2])) begin
        found    = 1'b1;
        exact    = (addr_q[idx] == ld_addr_i) && (type_q[idx] == ld_type_i);
        fwd_data = data_q[idx];
      end
    end
    if (ld_valid_i && found) begin
      if (exact) begin
        hit_o     = 1'b1;
        ld_data_o = fwd_data;
      end else begin
        conflict_o = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_segre_store_buffer.sv
// Testbench for segre_store_buffer: directed scenarios plus a randomized run,
// all checked against a queue-based reference model of the store buffer.

module tb_segre_store_buffer;
  import segre_sb_pkg::*;

  localparam int N = 4;

  logic             clk;
  logic             rsn;
  logic             st_valid;
  logic [31:0]      st_addr;
  logic [31:0]      st_data;
  memop_data_type_e st_type;
  logic             ld_valid;
  logic [31:0]      ld_addr;
  memop_data_type_e ld_type;
  logic             hit, conflict, drain_valid, drain_ready, full, empty;
  logic [31:0]      ld_data, drain_addr, drain_data;
  memop_data_type_e drain_type;

  int tests = 0;
  int fails = 0;

  segre_store_buffer #(.NUM_ENTRIES(N), .WORD_SIZE(32), .ADDR_SIZE(32)) dut (
    .clk_i(clk), .rsn_i(rsn),
    .st_valid_i(st_valid), .st_addr_i(st_addr), .st_data_i(st_data), .st_type_i(st_type),
    .ld_valid_i(ld_valid), .ld_addr_i(ld_addr), .ld_type_i(ld_type),
    .hit_o(hit), .ld_data_o(ld_data), .conflict_o(conflict),
    .drain_valid_o(drain_valid), .drain_addr_o(drain_addr), .drain_data_o(drain_data),
    .drain_type_o(drain_type), .drain_ready_i(drain_ready),
    .full_o(full), .empty_o(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: the buffer is an ordered queue, oldest at index 0.
  typedef struct {
    logic [31:0]      addr;
    logic [31:0]      data;
    memop_data_type_e typ;
  } ent_t;
  ent_t q[$];

  logic [102:0] obs_vec;
  assign obs_vec = {hit, conflict, ld_data, drain_valid, drain_addr, drain_data,
                    drain_type, full, empty};

  function automatic logic [102:0] exp_vec();
    logic h = 1'b0, c = 1'b0, dv = 1'b0;
    logic [31:0] ld = '0, da = '0, dd = '0;
    logic [1:0] dt = 2'b00;
    if (ld_valid) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].addr[31:2] == ld_addr[31:2]) begin
          if (q[i].addr == ld_addr && q[i].typ == ld_type) begin
            h  = 1'b1;
            ld = q[i].data;
          end else begin
            c = 1'b1;
          end
          break;
        end
      end
    end
    if (q.size() > 0) begin
      dv = 1'b1;
      da = q[0].addr;
      dd = q[0].data;
      dt = q[0].typ;
    end
    return {h, c, ld, dv, da, dd, dt, (q.size() == N), (q.size() == 0)};
  endfunction

  // Called at a negedge with inputs already applied; advances one cycle.
  task automatic tick();
    bit   do_push, do_pop;
    ent_t e;
    do_push = st_valid && (q.size() < N);
    do_pop  = (q.size() > 0) && drain_ready;
    e.addr = st_addr;
    e.data = st_data;
    e.typ  = st_type;
    @(posedge clk);
    if (rsn) begin
      q.delete();
    end else begin
      if (do_pop) e = q.pop_front();
      if (do_push) begin
        e.addr = st_addr;
        e.data = st_data;
        e.typ  = st_type;
        q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    st_valid = 1'b0; st_addr = '0; st_data = '0; st_type = BYTE;
    ld_valid = 1'b0; ld_addr = '0; ld_type = BYTE;
    drain_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rsn = 1'b1;
    tick();
    tick();
    rsn = 1'b0;
  endtask

  task automatic push_one(input logic [31:0] a, input logic [31:0] d, input memop_data_type_e t);
    st_valid = 1'b1; st_addr = a; st_data = d; st_type = t;
    tick();
    st_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rsn = 1'b1;
    tick();
    tick();
    ld_valid = 1'b1; ld_addr = 32'h0; ld_type = BYTE;
    #1;
    tests++;
    if (obs_vec !== {1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_values: got %h required all-zero with empty=1", obs_vec);
    end
    rsn = 1'b0;
    ld_valid = 1'b0;
  endtask

  task automatic test_push_drain();
    do_reset();
    push_one(32'h1000, 32'hDEADBEEF, WORD);
    #1;
    tests++;
    if ({drain_valid, drain_addr, drain_data, empty} !== {1'b1, 32'h1000, 32'hDEADBEEF, 1'b0}) begin
      fails++;
      $display("FAIL push_drain_head: got v=%b a=%h d=%h e=%b required v=1 a=1000 d=deadbeef e=0",
               drain_valid, drain_addr, drain_data, empty);
    end
    drain_ready = 1'b1;
    tick();
    drain_ready = 1'b0;
    #1;
    tests++;
    if ({empty, drain_valid} !== 2'b10) begin
      fails++;
      $display("FAIL push_drain_empty: got empty=%b valid=%b required empty=1 valid=0", empty, drain_valid);
    end
  endtask

  task automatic test_fill_wrap();
    logic [31:0] exp_order [6];
    logic [31:0] got;
    int          n_out;
    exp_order = '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h24, 32'h28};
    do_reset();
    for (int i = 0; i < 4; i++) push_one(32'h10 + 32'(4 * i), 32'hA0 + 32'(i), WORD);
    #1;
    tests++;
    if (full !== 1'b1) begin
      fails++;
      $display("FAIL fill_full: got full=%b required 1", full);
    end
    push_one(32'h20, 32'hBAD, WORD);
    #1;
    tests++;
    if (obs_vec !== exp_vec() || full !== 1'b1 || q.size() != 4) begin
      fails++;
      $display("FAIL fill_drop5th: got %h required %h", obs_vec, exp_vec());
    end
    n_out = 0;
    drain_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      got = drain_addr;
      tests++;
      if (got !== exp_order[n_out]) begin
        fails++;
        $display("FAIL wrap_order[%0d]: got %h required %h", n_out, got, exp_order[n_out]);
      end
      n_out++;
      tick();
    end
    drain_ready = 1'b0;
    push_one(32'h24, 32'hA4, WORD);
    push_one(32'h28, 32'hA5, WORD);
    drain_ready = 1'b1;
    for (int c = 0; c < 10 && drain_valid === 1'b1 && n_out < 6; c++) begin
      got = drain_addr;
      tests++;
      if (got !== exp_order[n_out]) begin
        fails++;
        $display("FAIL wrap_order[%0d]: got %h required %h", n_out, got, exp_order[n_out]);
      end
      n_out++;
      tick();
    end
    drain_ready = 1'b0;
    #1;
    tests++;
    if (n_out != 6 || empty !== 1'b1) begin
      fails++;
      $display("FAIL wrap_count: got %0d drained empty=%b required 6 drained empty=1", n_out, empty);
    end
  endtask

  task automatic test_youngest();
    do_reset();
    push_one(32'h2000, 32'h11111111, WORD);
    push_one(32'h2000, 32'h22222222, WORD);
    ld_valid = 1'b1; ld_addr = 32'h2000; ld_type = WORD;
    #1;
    tests++;
    if ({hit, conflict, ld_data} !== {1'b1, 1'b0, 32'h22222222}) begin
      fails++;
      $display("FAIL youngest_wins: got hit=%b conf=%b data=%h required hit=1 conf=0 data=22222222",
               hit, conflict, ld_data);
    end
    ld_valid = 1'b0;
    #1;
    tests++;
    if ({hit, conflict, ld_data} !== 34'h0) begin
      fails++;
      $display("FAIL lookup_idle: got hit=%b conf=%b data=%h required all 0", hit, conflict, ld_data);
    end
  endtask

  task automatic test_partial();
    do_reset();
    push_one(32'h3001, 32'hAB, BYTE);
    ld_valid = 1'b1; ld_addr = 32'h3000; ld_type = WORD;
    #1;
    tests++;
    if ({conflict, hit} !== 2'b10) begin
      fails++;
      $display("FAIL partial_conflict: got conf=%b hit=%b required conf=1 hit=0", conflict, hit);
    end
    drain_ready = 1'b1;
    tick();
    drain_ready = 1'b0;
    #1;
    tests++;
    if ({conflict, hit} !== 2'b00) begin
      fails++;
      $display("FAIL partial_after_drain: got conf=%b hit=%b required 0 0", conflict, hit);
    end
    ld_valid = 1'b0;
  endtask

  task automatic test_push_pop_count1();
    do_reset();
    push_one(32'h3FFC, 32'h5555, WORD);
    st_valid = 1'b1; st_addr = 32'h4000; st_data = 32'h6666; st_type = WORD;
    drain_ready = 1'b1;
    ld_valid = 1'b1; ld_addr = 32'h4000; ld_type = WORD;
    #1;
    tests++;
    if ({hit, drain_addr} !== {1'b0, 32'h3FFC}) begin
      fails++;
      $display("FAIL same_cycle_lookup: got hit=%b head=%h required hit=0 head=3ffc", hit, drain_addr);
    end
    tick();
    st_valid = 1'b0; drain_ready = 1'b0;
    #1;
    tests++;
    if ({drain_valid, drain_addr, drain_data, empty, full, hit} !==
        {1'b1, 32'h4000, 32'h6666, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL pushpop_head: got v=%b a=%h d=%h e=%b f=%b hit=%b required 1 4000 6666 0 0 1",
               drain_valid, drain_addr, drain_data, empty, full, hit);
    end
    drain_ready = 1'b1;
    tick();
    drain_ready = 1'b0;
    #1;
    tests++;
    if (empty !== 1'b1) begin
      fails++;
      $display("FAIL pushpop_count1: got empty=%b required 1 after one pop", empty);
    end
    ld_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_one(32'h500, 32'h1, WORD);
    push_one(32'h504, 32'h2, WORD);
    push_one(32'h508, 32'h3, WORD);
    drain_ready = 1'b1;
    rsn = 1'b1;
    tick();
    drain_ready = 1'b0;
    #1;
    tests++;
    if ({empty, drain_valid, full} !== 3'b100) begin
      fails++;
      $display("FAIL reset_mid_flags: got empty=%b valid=%b full=%b required 1 0 0", empty, drain_valid, full);
    end
    rsn = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_addr = 32'h500 + 32'(4 * i); ld_type = WORD;
      #1;
      tests++;
      if ({hit, conflict} !== 2'b00) begin
        fails++;
        $display("FAIL reset_mid_lookup[%0d]: got hit=%b conf=%b required 0 0", i, hit, conflict);
      end
    end
    ld_valid = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      st_valid    = ($urandom_range(0, 99) < 55);
      st_addr     = 32'h100 + 32'($urandom_range(0, 15));
      st_data     = $urandom;
      st_type     = memop_data_type_e'($urandom_range(0, 2));
      ld_valid    = ($urandom_range(0, 99) < 80);
      ld_addr     = 32'h100 + 32'($urandom_range(0, 15));
      ld_type     = memop_data_type_e'($urandom_range(0, 2));
      drain_ready = ($urandom_range(0, 99) < 45);
      rsn         = ($urandom_range(0, 199) == 0);
      #1;
      tests++;
      if (obs_vec !== exp_vec()) begin
        fails++;
        $display("FAIL random[%0d]: got %h required %h", c, obs_vec, exp_vec());
      end
      tick();
    end
    rsn = 1'b0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rsn = 1'b1;
    @(negedge clk);
    test_reset();
    test_push_drain();
    test_fill_wrap();
    test_youngest();
    test_partial();
    test_push_pop_count1();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
